dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder that serves load/store requests issued by the MEM stage through a valid/ready request channel and a single-cycle response pulse. It owns a byte-addressed, little-endian data array. It performs sub-word writes with byte lanes and sign/zero-extends sub-word reads. It flags misaligned or out-of-range accesses instead of executing them. It sits behind the MEM stage and replaces a zero-latency memory wherever the pipeline must tolerate a stall.

## Interface
- MEM_WIDTH, 8, bits per addressable array entry (one byte)
- DMEM_ADDR_WIDTH, 10, index width of the array
- REG_WIDTH, 32, request address/data width
- DMEM_DEPTH, 1024, number of bytes in the array
- ACCESS_LATENCY, 2, cycles from request acceptance to response (legal range 1..15)

- clk  in  1  clock; all logic is rising-edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  REG_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  REG_WIDTH  store data, taken from the low bytes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  REG_WIDTH  load result; 0 for stores and errors
- rsp_error  out  1  access rejected; qualified by rsp_valid

## Operation
- FSM states:
  - IDLE: req_ready=1. Handshake is req_valid&req_ready at the edge. Latch write, addr, size, unsigned, wdata. Reset the latency counter to 0. Next state is RESP if the access is illegal or ACCESS_LATENCY==1; otherwise WAIT.
  - WAIT: the counter increments each cycle. When counter==ACCESS_LATENCY-2, the access executes at that edge and the next state is RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE unconditionally. There is no response backpressure.
- Illegal access conditions: req_size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr+bytes > DMEM_DEPTH (full REG_WIDTH compare, no truncation). An illegal access executes no write, returns rsp_rdata=0, and sets rsp_error=1.
- Store: byte k of req_wdata goes to array[addr+k] for k < size bytes. Other bytes are untouched.
- Load: assemble array[addr+k] little-endian. Bytes and halves are extended to REG_WIDTH per req_unsigned. Words are unchanged.
- The array is cleared to zero by reset_n.
- rsp_rdata and rsp_error are registers. They update only on entry to RESP and hold their value until the next response.
- Requests presented outside IDLE are ignored and not latched. The requester must hold them until accepted.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0, array all zero.
- Legal access: with the handshake at edge E, rsp_valid is high in the cycle after edge E+ACCESS_LATENCY−1. The access is therefore ACCESS_LATENCY cycles after the acceptance cycle.
- Illegal access: rsp_valid is high in the cycle after E, regardless of ACCESS_LATENCY.
- Throughput: one request per ACCESS_LATENCY+1 cycles. req_ready is low from the cycle after the handshake through the RESP cycle, and high again in the cycle after RESP.
- Store commit point: the edge that enters RESP. A load issued immediately after a store to the same address returns the new data.
- Reset mid-operation: immediate return to IDLE and rsp_valid drops asynchronously. A store that has not yet reached its commit edge is discarded. The array clears.
- Counter width is 4 bits. It never wraps, because the FSM leaves WAIT before the count exceeds 14.

## Test plan
- Reset, then word store 0xDEADBEEF @0x10, then unsigned word load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0. rsp_valid is high exactly 2 cycles after each acceptance cycle and req_ready is low in between.
- Byte store 0x80 @0x13, then signed byte load @0x13 -> 0xFFFFFF80. Unsigned byte load -> 0x00000080. Word load @0x10 -> 0x80ADBEEF.
- Half load @0x11 -> rsp_error=1, rdata=0, rsp_valid one cycle after acceptance. Word store @0x3FE -> error, and a following read shows memory unchanged. req_size=11 -> error.
- req_valid held high continuously with ACCESS_LATENCY=1 -> acceptances every 2 cycles, no request lost or duplicated, and responses come in order.
- reset_n asserted in WAIT during a store of 0x12345678 @0x20 -> rsp_valid never pulses. After release, req_ready=1 and a load @0x20 returns 0.
- ACCESS_LATENCY=4: word load @0x0 after reset -> 0x00000000 with rsp_valid 4 cycles after the acceptance cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the MEM stage
// (master) and the data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend sub-word loads when 1
//   req_wdata           : store data, low bytes used
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : load result (0 for stores and errors)
//   rsp_error           : access rejected, qualified by rsp_valid
interface dmem_responder_if #(
    parameter int REG_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [REG_WIDTH-1:0] req_addr;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [REG_WIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic [REG_WIDTH-1:0] rsp_rdata;
    logic                 rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte-addressed little-endian data memory.
// Accepts one load/store in IDLE, waits ACCESS_LATENCY cycles, then pulses
// a response. Misaligned, oversized or out-of-range accesses are rejected
// with rsp_error and answered one cycle after acceptance.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (also clears the array)
//   bus     : dmem_responder_if slave modport (request + response)
module dmem_responder #(
    parameter int MEM_WIDTH       = 8,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_DEPTH      = 1024,
    parameter int ACCESS_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_responder_if.slave   bus
);

    localparam int          NLANES   = 32'sd4;
    // Count value at which the WAIT state commits the access.
    localparam logic [3:0]  LAST_CNT = 4'(ACCESS_LATENCY - 32'sd2);
    localparam bit          ONE_CYC  = (ACCESS_LATENCY == 32'sd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [3:0]                 cnt_r;
    logic                       write_r;
    logic                       unsigned_r;
    logic [REG_WIDTH-1:0]       addr_r;
    logic [REG_WIDTH-1:0]       wdata_r;
    logic [1:0]                 size_r;
    logic                       ready_r;
    logic                       rsp_valid_r;
    logic                       rsp_error_r;
    logic [REG_WIDTH-1:0]       rsp_rdata_r;
    logic [MEM_WIDTH-1:0]       mem_r [DMEM_DEPTH];

    logic                       op_write_s;
    logic                       op_unsigned_s;
    logic [REG_WIDTH-1:0]       op_addr_s;
    logic [REG_WIDTH-1:0]       op_wdata_s;
    logic [1:0]                 op_size_s;
    logic [2:0]                 nbytes_s;
    logic [REG_WIDTH:0]         end_s;
    logic                       illegal_s;
    logic                       accept_s;
    logic                       reject_s;
    logic                       exec_s;
    logic [DMEM_ADDR_WIDTH-1:0] idx_s     [NLANES];
    logic [MEM_WIDTH-1:0]       rd_byte_s [NLANES];
    logic [REG_WIDTH-1:0]       load_s;

    // Operand source: live request when a single-cycle access executes from IDLE, else the latched copy.
    always_comb begin
        if (state_r == IDLE) begin
            op_write_s    = bus.req_write;
            op_unsigned_s = bus.req_unsigned;
            op_addr_s     = bus.req_addr;
            op_wdata_s    = bus.req_wdata;
            op_size_s     = bus.req_size;
        end else begin
            op_write_s    = write_r;
            op_unsigned_s = unsigned_r;
            op_addr_s     = addr_r;
            op_wdata_s    = wdata_r;
            op_size_s     = size_r;
        end
    end

    // Access legality: size code, alignment and range (one extra bit so addr+bytes cannot wrap).
    always_comb begin
        case (op_size_s)
            2'b00:   nbytes_s = 3'd1;
            2'b01:   nbytes_s = 3'd2;
            2'b10:   nbytes_s = 3'd4;
            default: nbytes_s = 3'd0;
        endcase
        end_s     = {1'b0, op_addr_s} + (REG_WIDTH + 1)'(nbytes_s);
        illegal_s = (op_size_s == 2'b11)
                 || ((op_size_s == 2'b01) && (op_addr_s[0] != 1'b0))
                 || ((op_size_s == 2'b10) && (op_addr_s[1:0] != 2'b00))
                 || (end_s > (REG_WIDTH + 1)'(DMEM_DEPTH));
    end

    // Byte lane addressing and little-endian load assembly with sign/zero extension.
    always_comb begin
        for (int k = 32'sd0; k < NLANES; k++) begin
            idx_s[k]     = op_addr_s[DMEM_ADDR_WIDTH-1:0] + DMEM_ADDR_WIDTH'(k);
            rd_byte_s[k] = mem_r[idx_s[k]];
        end
        case (op_size_s)
            2'b00:   load_s = {{(REG_WIDTH - MEM_WIDTH){~op_unsigned_s & rd_byte_s[0][MEM_WIDTH-1]}},
                               rd_byte_s[0]};
            2'b01:   load_s = {{(REG_WIDTH - 2 * MEM_WIDTH){~op_unsigned_s & rd_byte_s[1][MEM_WIDTH-1]}},
                               rd_byte_s[1], rd_byte_s[0]};
            2'b10:   load_s = {rd_byte_s[3], rd_byte_s[2], rd_byte_s[1], rd_byte_s[0]};
            default: load_s = {REG_WIDTH{1'b0}};
        endcase
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        reject_s = 1'b0;
        exec_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (illegal_s) begin
                        reject_s = 1'b1;
                        state_s  = RESP;
                    end else if (ONE_CYC) begin
                        exec_s  = 1'b1;
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == LAST_CNT) begin
                    exec_s  = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, latency counter and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            unsigned_r  <= 1'b0;
            addr_r      <= {REG_WIDTH{1'b0}};
            wdata_r     <= {REG_WIDTH{1'b0}};
            size_r      <= 2'b00;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r      <= 4'd0;
                write_r    <= bus.req_write;
                unsigned_r <= bus.req_unsigned;
                addr_r     <= bus.req_addr;
                wdata_r    <= bus.req_wdata;
                size_r     <= bus.req_size;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + 4'd1;
            end
            ready_r     <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RESP);
        end
    end

    // Response data: loaded on entry to RESP and held until the next response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata_r <= {REG_WIDTH{1'b0}};
            rsp_error_r <= 1'b0;
        end else if (reject_s) begin
            rsp_rdata_r <= {REG_WIDTH{1'b0}};
            rsp_error_r <= 1'b1;
        end else if (exec_s) begin
            rsp_rdata_r <= op_write_s ? {REG_WIDTH{1'b0}} : load_s;
            rsp_error_r <= 1'b0;
        end
    end

    // Data array: cleared by reset, byte-lane writes commit on the edge entering RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 32'sd0; i < DMEM_DEPTH; i++) begin
                mem_r[i] <= {MEM_WIDTH{1'b0}};
            end
        end else if (exec_s && op_write_s) begin
            for (int k = 32'sd0; k < NLANES; k++) begin
                if (3'(k) < nbytes_s) begin
                    mem_r[idx_s[k]] <= op_wdata_s[k * MEM_WIDTH +: MEM_WIDTH];
                end
            end
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_error = rsp_error_r;

endmodule
